// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit shift-register FSM state encoding.
`timescale 1ns/1ps
package uart_pkg;

    localparam int DATA_WIDTH_DEF      = 8;
    localparam int CHARACTER_COUNT_DEF = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } tx_sr_state_t;

endpackage

// File: rtl/uart_sr_output_if.sv
// Character stream from the buffer sequencer into the uart transmitter.
`timescale 1ns/1ps
interface uart_sr_output_if #(
    parameter int DATA_WIDTH = 8
);
    // A character moves when tx_valid & tx_ready are high in the same cycle;
    // once raised, tx_valid and tx_data stay stable until that transfer.
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sr_output.sv
// Snapshots a character buffer on start and streams it, highest character
// first, into the uart transmitter handshake.
`timescale 1ns/1ps
module uart_sr_output
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int CHARACTER_COUNT = CHARACTER_COUNT_DEF,
    parameter bit SKIP_ZERO       = 1'b0,
    localparam int IDX_W = (CHARACTER_COUNT > 1) ? $clog2(CHARACTER_COUNT) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ena,
    input  logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [IDX_W-1:0]                      char_index,
    uart_sr_output_if.master                      tx,
    output tx_sr_state_t                          dbg_state
);

    localparam int              SNAP_W   = DATA_WIDTH * CHARACTER_COUNT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARACTER_COUNT - 1);

    tx_sr_state_t          state_q, state_d;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] cur_char;
    logic                  char_skip;
    logic                  xfer;

    assign cur_char  = snap_q[DATA_WIDTH*int'(idx_q) +: DATA_WIDTH];
    assign char_skip = SKIP_ZERO && (cur_char == '0);
    assign xfer      = valid_q && tx.tx_ready;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        // With ena low every register simply holds.
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_d  = sr_data;
                        idx_d   = LAST_IDX;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (char_skip) begin
                        if (idx_q == '0) state_d = FIN;
                        else             idx_d   = idx_q - IDX_W'(1);
                    end else begin
                        data_d  = cur_char;
                        valid_d = 1'b1;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        valid_d = 1'b0;
                        if (idx_q == '0) begin
                            state_d = FIN;
                        end else begin
                            idx_d   = idx_q - IDX_W'(1);
                            state_d = GAP;
                        end
                    end
                end
                // One dead cycle so the transmitter can drop tx_ready.
                GAP:     state_d = LOAD;
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign busy        = (state_q != IDLE) && (state_q != FIN);
    assign done        = (state_q == FIN);
    assign char_index  = idx_q;
    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_sr_output.sv
// Directed bench for uart_sr_output: plain and zero-skipping instances.
`timescale 1ns/1ps
module tb_uart_sr_output;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int CC = 10;
    localparam int IW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, ena;

    logic [DW*CC-1:0] sr_a, sr_b;
    logic             start_a, start_b;
    logic             busy_a, busy_b, done_a, done_b;
    logic [IW-1:0]    idx_a, idx_b;
    tx_sr_state_t     dbg_a, dbg_b;

    uart_sr_output_if #(.DATA_WIDTH(DW)) if_a ();
    uart_sr_output_if #(.DATA_WIDTH(DW)) if_b ();

    uart_sr_output #(.DATA_WIDTH(DW), .CHARACTER_COUNT(CC), .SKIP_ZERO(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .ena(ena), .sr_data(sr_a), .start(start_a),
        .busy(busy_a), .done(done_a), .char_index(idx_a), .tx(if_a.master),
        .dbg_state(dbg_a)
    );

    uart_sr_output #(.DATA_WIDTH(DW), .CHARACTER_COUNT(CC), .SKIP_ZERO(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .ena(ena), .sr_data(sr_b), .start(start_b),
        .busy(busy_b), .done(done_b), .char_index(idx_b), .tx(if_b.master),
        .dbg_state(dbg_b)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_a[$];
    logic [DW-1:0] got_b[$];
    int  done_a_cnt, done_b_cnt;
    bit  valid_b_seen;
    int  checks = 0;
    int  errors = 0;

    // Inputs only move 1ns after posedge, so the negedge sees settled values.
    always @(negedge clk) begin
        if (reset_n && ena) begin
            if (if_a.tx_valid && if_a.tx_ready) got_a.push_back(if_a.tx_data);
            if (if_b.tx_valid && if_b.tx_ready) got_b.push_back(if_b.tx_data);
            if (if_b.tx_valid) valid_b_seen = 1'b1;
            if (done_a) done_a_cnt++;
            if (done_b) done_b_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_a(input string tag);
        chk({tag, "_count"}, got_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_a.size()) chk({tag, "_char"}, got_a[i], exp_q[i]);
    endtask

    task automatic cmp_b(input string tag);
        chk({tag, "_count"}, got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_b.size()) chk({tag, "_char"}, got_b[i], exp_q[i]);
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_state"}, 32'(dbg_a), 32'(IDLE));
        chk({tag, "_flags"}, {if_a.tx_valid, busy_a, done_a, idx_a}, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  n;
        bit  found;
        reset_n = 1'b0;
        ena     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sr_a    = '0;
        sr_b    = '0;
        if_a.tx_ready = 1'b1;
        if_b.tx_ready = 1'b1;
        done_a_cnt = 0;
        done_b_cnt = 0;
        valid_b_seen = 1'b0;

        // Reset then idle
        repeat (3) tick();
        chk_idle_a("in_reset");
        chk("in_reset_data", if_a.tx_data, 8'h00);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle_a("idle_a");
            chk("idle_b", {if_b.tx_valid, busy_b, done_b, idx_b}, 32'h0);
        end

        // Full buffer, tx_ready high: "0123456789" sends 0x30..0x39
        sr_a = "0123456789";
        exp_q.delete();
        for (int k = 0; k < CC; k++) exp_q.push_back(8'(8'h30 + k));
        got_a.delete();
        done_a_cnt = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("lat_load_state", 32'(dbg_a), 32'(LOAD));
        chk("lat_load_busy", busy_a, 1'b1);
        chk("lat_load_valid", if_a.tx_valid, 1'b0);
        chk("lat_load_idx", idx_a, 4'd9);
        tick();
        chk("lat_send_valid", if_a.tx_valid, 1'b1);
        chk("lat_send_data", if_a.tx_data, 8'h30);
        n = 2;
        while (!done_a && n < 100) begin
            tick();
            n++;
        end
        chk("full_done_seen", done_a, 1'b1);
        chk("full_cycles", n, 30);
        chk("fin_busy", busy_a, 1'b0);
        tick();
        chk_idle_a("full_after");
        cmp_a("full");
        chk("full_done_cnt", done_a_cnt, 1);

        // Stall 50 cycles while char 3 ('6') is offered
        got_a.delete();
        done_a_cnt = 0;
        found = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 400) begin
            if (!found && if_a.tx_valid && idx_a == 4'd3) begin
                found = 1'b1;
                if_a.tx_ready = 1'b0;
                chk("stall_first_data", if_a.tx_data, 8'h36);
                for (int s = 0; s < 50; s++) begin
                    tick();
                    chk("stall_valid", if_a.tx_valid, 1'b1);
                    chk("stall_data", if_a.tx_data, 8'h36);
                    chk("stall_idx", idx_a, 4'd3);
                end
                if_a.tx_ready = 1'b1;
            end
            tick();
            n++;
        end
        chk("stall_reached", found, 1'b1);
        chk("stall_done_seen", done_a, 1'b1);
        tick();
        cmp_a("stall");
        chk("stall_done_cnt", done_a_cnt, 1);

        // New data and start mid-transfer are ignored; start in FIN ignored
        got_a.delete();
        done_a_cnt = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        sr_a = "ABCDEFGHIJ";
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_busy", busy_a, 1'b1);
        n = 0;
        while (!done_a && n < 100) begin
            tick();
            n++;
        end
        chk("restart_done_seen", done_a, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk_idle_a("fin_start_ignored");
        tick();
        chk_idle_a("fin_start_ignored2");
        cmp_a("restart");
        chk("restart_done_cnt", done_a_cnt, 1);
        sr_a = "0123456789";

        // SKIP_ZERO: chars 9 and 0 nonzero, everything else zero
        sr_b = '0;
        sr_b[DW*CC-1 -: DW] = 8'h41;
        sr_b[DW-1:0] = 8'h42;
        exp_q.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        got_b.delete();
        done_b_cnt = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 100) begin
            tick();
            n++;
        end
        chk("skip_done_seen", done_b, 1'b1);
        chk("skip_cycles", n, 14);
        tick();
        cmp_b("skip");
        chk("skip_done_cnt", done_b_cnt, 1);

        // SKIP_ZERO with an all-zero buffer: no tx_valid, done after CC loads
        sr_b = '0;
        got_b.delete();
        done_b_cnt = 0;
        valid_b_seen = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 100) begin
            tick();
            n++;
        end
        chk("zero_done_seen", done_b, 1'b1);
        chk("zero_cycles", n, 11);
        tick();
        chk("zero_no_xfer", got_b.size(), 0);
        chk("zero_no_valid", valid_b_seen, 1'b0);
        chk("zero_done_cnt", done_b_cnt, 1);

        // ena freeze while char 4 ('5') is offered, then reset mid-char
        done_a_cnt = 0;
        found = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            tick();
            n++;
            if (if_a.tx_valid && idx_a == 4'd4) found = 1'b1;
        end
        chk("freeze_reached", found, 1'b1);
        ena = 1'b0;
        start_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("freeze_state", 32'(dbg_a), 32'(SEND));
            chk("freeze_valid", if_a.tx_valid, 1'b1);
            chk("freeze_data", if_a.tx_data, 8'h35);
            chk("freeze_idx", idx_a, 4'd4);
            chk("freeze_busy_done", {busy_a, done_a}, 2'b10);
        end
        start_a = 1'b0;
        ena = 1'b1;
        if_a.tx_ready = 1'b0;
        tick();
        chk("hold_state", 32'(dbg_a), 32'(SEND));
        chk("hold_data", if_a.tx_data, 8'h35);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_idle_a("async_reset");
        chk("async_reset_data", if_a.tx_data, 8'h00);
        tick();
        tick();
        reset_n = 1'b1;
        if_a.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle_a("post_reset");
        end
        chk("reset_no_done", done_a_cnt, 0);

        // start with ena low in IDLE is ignored
        ena = 1'b0;
        start_a = 1'b1;
        tick();
        chk_idle_a("ena_low_start");
        start_a = 1'b0;
        ena = 1'b1;
        tick();
        chk_idle_a("ena_low_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
